// File: rtl/demux_dispatch_pkg.sv
// rtl/demux_dispatch_pkg.sv - shared types and sizes for the round-robin demux dispatcher
package demux_dispatch_pkg;
  localparam int NCH    = 8;
  localparam int CH_W   = 3;
  localparam int STAT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } disp_state_t;
endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - first set bit of an 8-bit mask, searching upward from ptr with wrap
module rr_pick8
  import demux_dispatch_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  logic [CH_W-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < NCH; k++) begin
      pos = ptr + CH_W'(k);
      if (!any && mask[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// rtl/demux_rr_dispatcher.sv - round-robin 1:8 word dispatcher with registered demux and stall watchdog
// Optional per-channel delivery / drop statistics: DEMUX_DISPATCH_STATS_EN
module demux_rr_dispatcher
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH-1:0]        chan_en,
  input  logic [NCH-1:0]        chan_ready,
  output logic [CH_W-1:0]       sel,
  output logic [NCH-1:0]        out_valid,
  output logic [NCH*DATA_W-1:0] y,
`ifdef DEMUX_DISPATCH_STATS_EN
  input  logic [CH_W-1:0]       stat_sel,
  output logic [STAT_W-1:0]     stat_cnt,
  output logic [STAT_W-1:0]     drop_cnt,
`endif
  output logic                  drop
);

  disp_state_t       state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              drop_q, drop_d;

  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic              accept, deliver;

  rr_pick8 u_pick (
    .mask (chan_en),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Selection never looks at chan_ready; readiness only gates acceptance of the next word.
  assign deliver  = (state_q == HOLD) && chan_ready[ch_q];
  assign in_ready = pick_any && ((state_q == IDLE) || deliver);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: ;
      HOLD: begin
        if (deliver) begin
          state_d = IDLE;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d = IDLE;
          cnt_d   = '0;
          drop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = HOLD;
      data_d  = in_data;
      ch_d    = pick_idx;
      ptr_d   = pick_idx + CH_W'(1);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign sel  = ch_q;
  assign drop = drop_q;

  always_comb begin
    out_valid = '0;
    if (state_q == HOLD) out_valid[ch_q] = 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_slice
    assign y[i*DATA_W +: DATA_W] = ((state_q == HOLD) && (ch_q == CH_W'(i))) ? data_q : '0;
  end

`ifdef DEMUX_DISPATCH_STATS_EN
  logic [STAT_W-1:0] dcnt_q [NCH];
  logic [STAT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) dcnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (deliver && (dcnt_q[ch_q] != '1)) dcnt_q[ch_q] <= dcnt_q[ch_q] + STAT_W'(1);
      if (drop_d && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + STAT_W'(1);
    end
  end

  assign stat_cnt = dcnt_q[stat_sel];
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb/tb_demux_rr_dispatcher.sv - directed self-checking bench for demux_rr_dispatcher
module tb_demux_rr_dispatcher;

  localparam int DW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    chan_en;
  logic [7:0]    chan_ready;
  logic [2:0]    sel;
  logic [7:0]    out_valid;
  logic [8*DW-1:0] y;
  logic          drop;
`ifdef DEMUX_DISPATCH_STATS_EN
  logic [2:0]    stat_sel;
  logic [15:0]   stat_cnt;
  logic [15:0]   drop_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  demux_rr_dispatcher #(.DATA_W(DW), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .chan_en    (chan_en),
    .chan_ready (chan_ready),
    .sel        (sel),
    .out_valid  (out_valid),
    .y          (y),
`ifdef DEMUX_DISPATCH_STATS_EN
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt),
    .drop_cnt   (drop_cnt),
`endif
    .drop       (drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // sel, one-hot valid and the data placed in slice ch
  task automatic check_held(input string tag, input int ch, input logic [DW-1:0] d);
    check({tag, ".sel"}, 32'(sel), 32'(ch));
    check({tag, ".ov"}, 32'(out_valid), 32'(8'(1) << ch));
    check({tag, ".y"}, 32'(y), 32'(8'(d) << (ch * DW)));
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; chan_en = 8'h00; chan_ready = 8'h00;
`ifdef DEMUX_DISPATCH_STATS_EN
    stat_sel = 3'd0;
`endif
    tick(); tick();
    check("rst.sel", 32'(sel), 32'd0);
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.y", 32'(y), 32'd0);
    check("rst.drop", 32'(drop), 32'd0);
    check("rst.rdy_en0", 32'(in_ready), 32'd0);
    rst = 1'b0;
    chan_en = 8'hFF;
    #1;
    check("rst.rdy_enff", 32'(in_ready), 32'd1);

    // rotation over all channels, alternating data 1,0,1,...
    chan_ready = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      in_data = DW'((k % 2) == 0);
      in_valid = 1'b1;
      #1;
      check("rot.rdy", 32'(in_ready), 32'd1);
      tick();
      check_held("rot", k % 8, DW'((k % 2) == 0));
      check("rot.drop", 32'(drop), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("rot.end_ov", 32'(out_valid), 32'd0);

    // mask skip from a fresh pointer
    do_reset();
    chan_en = 8'b1000_0101;
    chan_ready = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      in_data = 1'b1;
      in_valid = 1'b1;
      tick();
      case (k % 3)
        0: check_held("mask", 0, 1'b1);
        1: check_held("mask", 2, 1'b1);
        default: check_held("mask", 7, 1'b1);
      endcase
    end
    in_valid = 1'b0;
    tick();
    chan_en = 8'h00;
    in_valid = 1'b1;
    #1;
    check("mask.en0_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // backpressure on channel 3, then back-to-back redelivery
    do_reset();
    chan_en = 8'h08;
    chan_ready = 8'h00;
    in_data = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_held("bp.load", 3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.rdy_lo", 32'(in_ready), 32'd0);
      tick();
      check_held("bp.stall", 3, 1'b1);
    end
    chan_ready = 8'h08;
    in_data = 1'b0;
    in_valid = 1'b1;
    #1;
    check("bp.rdy_hi", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_held("bp.b2b", 3, 1'b0);
    tick();
    check("bp.end_ov", 32'(out_valid), 32'd0);

    // watchdog: channel 4 never ready
    do_reset();
    chan_en = 8'hFF;
    chan_ready = 8'hEF;
    for (int k = 0; k < 5; k++) begin
      in_data = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_held("wd.load", 4, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("wd.nodrop", 32'(drop), 32'd0);
      check("wd.held", 32'(out_valid), 32'h10);
    end
    in_valid = 1'b1;
    #1;
    check("wd.rdy_lo", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    check("wd.drop", 32'(drop), 32'd1);
    check("wd.ov0", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("wd.drop_once", 32'(drop), 32'd0);
    check_held("wd.next", 5, 1'b1);

    // delivery in the timeout cycle wins
    do_reset();
    chan_en = 8'h08;
    chan_ready = 8'h00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    chan_ready = 8'h08;
    tick();
    check("race.drop", 32'(drop), 32'd0);
    check("race.ov", 32'(out_valid), 32'd0);
    tick();
    check("race.drop2", 32'(drop), 32'd0);

    // reset while holding for channel 6
    do_reset();
    chan_en = 8'hFF;
    chan_ready = 8'hBF;
    for (int k = 0; k < 7; k++) begin
      in_data = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_held("rmh.load", 6, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmh.ov", 32'(out_valid), 32'd0);
    check("rmh.y", 32'(y), 32'd0);
    check("rmh.sel", 32'(sel), 32'd0);
    check("rmh.drop", 32'(drop), 32'd0);
    chan_ready = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rmh.drop2", 32'(drop), 32'd0);
    check_held("rmh.first", 0, 1'b1);
    tick();

`ifdef DEMUX_DISPATCH_STATS_EN
    do_reset();
    chan_en = 8'hFF;
    chan_ready = 8'hFF;
    in_data = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chan_en = 8'h01;
    chan_ready = 8'h00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("st.drop_cnt", 32'(drop_cnt), 32'd1);
    for (int c = 0; c < 8; c++) begin
      stat_sel = 3'(c);
      #1;
      check("st.cnt", 32'(stat_cnt), (c < 2) ? 32'd2 : 32'd1);
    end
    chan_ready = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    tick();
    stat_sel = 3'd0;
    #1;
    check("st.sat", 32'(stat_cnt), 32'hFFFF);
    check("st.drop_cnt2", 32'(drop_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
